// File: rtl/audio_pkg.sv
// Shared definitions for the note sequencer: step-table entry layout and FSM state encoding.
package audio_pkg;

  localparam int ENTRY_W  = 24;
  localparam int INC_W    = 16;
  localparam int INC_MSB  = 23;
  localparam int INC_LSB  = 8;
  localparam int REST_BIT = 7;
  localparam int DUR_W    = 7;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_LOAD = 3'd1;
  localparam state_t ST_PLAY = 3'd2;
  localparam state_t ST_GAP  = 3'd3;
  localparam state_t ST_END  = 3'd4;

  typedef struct packed {
    logic [INC_W-1:0] inc;
    logic             rest;
    logic [DUR_W-1:0] dur;
  } entry_t;

  function automatic entry_t unpack_entry(input logic [ENTRY_W-1:0] raw);
    entry_t e;
    e.inc  = raw[INC_MSB:INC_LSB];
    e.rest = raw[REST_BIT];
    e.dur  = raw[DUR_W-1:0];
    return e;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Tempo prescaler: counts 0..tempo_div and flags tick on the terminal count, then wraps.
// A count already beyond a newly lowered tempo_div runs on to 16'hFFFF and wraps naturally.
module tick_prescaler (
  input  logic        sample_clock,
  input  logic        rst,
  input  logic        clr,
  input  logic [15:0] tempo_div,
  output logic        tick
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    tick  = (cnt_q == tempo_div);
    cnt_d = cnt_q + 16'd1;
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge sample_clock or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Step-table player driving one voice's pitch_increment and gate at a prescaled tempo.
// Each step: one LOAD cycle, duration ticks of note, one tick of gap so the envelope retriggers.
module note_sequencer
  import audio_pkg::*;
#(
  parameter int STEPS = 16,
  parameter int IDX_W = $clog2(STEPS)
) (
  input  logic               sample_clock,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic [15:0]        tempo_div,
  input  logic               loop,
  input  logic               start,
  input  logic               stop,
  output logic [INC_W-1:0]   pitch_increment,
  output logic               gate,
  output logic [IDX_W-1:0]   step_index,
  output logic               busy,
  output logic               done
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic [DUR_W-1:0]   remain_q, remain_d;
  logic [INC_W-1:0]   pitch_q, pitch_d;
  logic               gate_q, gate_d;
  logic [ENTRY_W-1:0] tbl_q [STEPS];
  logic [ENTRY_W-1:0] tbl_d [STEPS];

  logic   tick;
  logic   last_step;
  entry_t cur_entry;

  // Holding the count at zero through LOAD makes the first PLAY cycle count 0.
  tick_prescaler u_prescaler (
    .sample_clock (sample_clock),
    .rst          (rst),
    .clr          (state_q == ST_LOAD),
    .tempo_div    (tempo_div),
    .tick         (tick)
  );

  assign cur_entry = unpack_entry(tbl_q[index_q]);
  assign last_step = (index_q == IDX_W'(STEPS - 1));

  always_ff @(posedge sample_clock or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      index_q  <= '0;
      remain_q <= '0;
      pitch_q  <= '0;
      gate_q   <= 1'b0;
      for (int i = 0; i < STEPS; i++) begin
        tbl_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      remain_q <= remain_d;
      pitch_q  <= pitch_d;
      gate_q   <= gate_d;
      tbl_q    <= tbl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: state_d = (cur_entry.dur == '0) ? ST_END : ST_PLAY;
      ST_PLAY: if (tick && remain_q == DUR_W'(1)) state_d = ST_GAP;
      ST_GAP: begin
        if (tick) begin
          state_d = (last_step && !loop) ? ST_END : ST_LOAD;
        end
      end
      ST_END:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (stop) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    index_d  = index_q;
    remain_d = remain_q;
    pitch_d  = pitch_q;
    gate_d   = gate_q;
    tbl_d    = tbl_q;
    // LOAD reads tbl_q, so a same-cycle write to that address lands after the read.
    if (wr_en) begin
      tbl_d[wr_addr] = wr_data;
    end
    case (state_q)
      ST_IDLE: begin
        gate_d = 1'b0;
        if (start) index_d = '0;
      end
      ST_LOAD: begin
        gate_d = 1'b0;
        if (cur_entry.dur != '0) begin
          pitch_d  = cur_entry.inc;
          gate_d   = ~cur_entry.rest;
          remain_d = cur_entry.dur;
        end
      end
      ST_PLAY: begin
        if (tick) begin
          if (remain_q == DUR_W'(1)) gate_d = 1'b0;
          else remain_d = remain_q - DUR_W'(1);
        end
      end
      ST_GAP: begin
        if (tick) begin
          if (!last_step) index_d = index_q + 1'b1;
          else if (loop) index_d = '0;
        end
      end
      default: gate_d = 1'b0;
    endcase
    if (stop) begin
      gate_d = 1'b0;
    end
  end

  always_comb begin
    pitch_increment = pitch_q;
    gate            = gate_q;
    step_index      = index_q;
    busy            = (state_q != ST_IDLE);
    done            = (state_q == ST_END);
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench: directed vector table, hand sequences for corner cases, random tables vs a trace model.
module tb_note_sequencer;

  logic        sample_clock = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [23:0] wr_data = '0;
  logic [15:0] tempo_div = '0;
  logic        loop = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] pitch_increment;
  logic        gate;
  logic [3:0]  step_index;
  logic        busy;
  logic        done;

  note_sequencer #(.STEPS(16)) dut (
    .sample_clock    (sample_clock),
    .rst             (rst),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .tempo_div       (tempo_div),
    .loop            (loop),
    .start           (start),
    .stop            (stop),
    .pitch_increment (pitch_increment),
    .gate            (gate),
    .step_index      (step_index),
    .busy            (busy),
    .done            (done)
  );

  always #5 sample_clock = ~sample_clock;

  typedef struct packed {
    logic        gate;
    logic [15:0] pitch;
    logic [3:0]  idx;
    logic        busy;
    logic        done;
  } obs_t;

  typedef struct {
    logic [15:0] tempo;
    logic [15:0] inc;
    logic        rest;
    logic [6:0]  dur;
    int          exp_hi;
    int          exp_busy;
    int          exp_done_at;
    logic [15:0] exp_pitch;
  } vec_t;

  int total = 0;
  int bad = 0;

  logic [23:0] model_tbl [16];
  logic [15:0] model_pitch;
  obs_t        exp_q [$];
  int          done_seen, wrap_seen, gate_rises;

  task automatic step();
    @(posedge sample_clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wr(input int a, input logic [23:0] d);
    wr_en = 1'b1;
    wr_addr = 4'(a);
    wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  function automatic obs_t mk(input logic g, input logic [15:0] p, input int i,
                              input logic b, input logic d);
    obs_t o;
    o.gate = g; o.pitch = p; o.idx = 4'(i); o.busy = b; o.done = d;
    return o;
  endfunction

  function automatic obs_t sample_dut();
    return mk(gate, pitch_increment, int'(step_index), busy, done);
  endfunction

  // Expected per-cycle trace after a start pulse, built step by step from the table.
  task automatic build(input int period, input bit lp, input int maxc);
    int  idx;
    int  dur;
    logic g;
    bit  fin;
    exp_q.delete();
    idx = 0;
    fin = 1'b0;
    while (!fin && exp_q.size() < maxc) begin
      exp_q.push_back(mk(1'b0, model_pitch, idx, 1'b1, 1'b0));
      dur = int'(model_tbl[idx][6:0]);
      if (dur == 0) begin
        exp_q.push_back(mk(1'b0, model_pitch, idx, 1'b1, 1'b1));
        fin = 1'b1;
      end else begin
        model_pitch = model_tbl[idx][23:8];
        g = !model_tbl[idx][7];
        for (int k = 0; k < dur * period; k++) exp_q.push_back(mk(g, model_pitch, idx, 1'b1, 1'b0));
        for (int k = 0; k < period; k++) exp_q.push_back(mk(1'b0, model_pitch, idx, 1'b1, 1'b0));
        if (idx == 15) begin
          if (lp) idx = 0;
          else begin
            exp_q.push_back(mk(1'b0, model_pitch, idx, 1'b1, 1'b1));
            fin = 1'b1;
          end
        end else begin
          idx++;
        end
      end
    end
    if (fin) exp_q.push_back(mk(1'b0, model_pitch, idx, 1'b0, 1'b0));
  endtask

  task automatic run_trace(input int n, input string name);
    obs_t act, prev;
    bit   ok;
    done_seen = 0; wrap_seen = 0; gate_rises = 0;
    prev = sample_dut();
    pulse_start();
    for (int i = 0; i < n; i++) begin
      act = sample_dut();
      ok = (act === exp_q[i]);
      check(name, 32'(act), 32'(exp_q[i]));
      if (!ok) break;
      if (act.done) done_seen++;
      if (prev.idx == 4'd15 && act.idx == 4'd0 && prev.busy) wrap_seen++;
      if (act.gate && !prev.gate) gate_rises++;
      prev = act;
      if (i < n - 1) step();
    end
  endtask

  initial begin
    vec_t vecs[6];
    int   hi, bsy, dn, dn_at, n;
    logic [15:0] last_p;
    bit   fin;

    vecs[0] = '{16'd0, 16'h1111, 1'b0, 7'd0,   0,   2,   2,   16'h0000};
    vecs[1] = '{16'd3, 16'h1234, 1'b0, 7'd2,   8,  15,  15,   16'h1234};
    vecs[2] = '{16'd3, 16'h5678, 1'b1, 7'd3,   0,  19,  19,   16'h5678};
    vecs[3] = '{16'd0, 16'hABCD, 1'b0, 7'd1,   1,   5,   5,   16'hABCD};
    vecs[4] = '{16'd1, 16'h00FF, 1'b0, 7'd5,  10,  15,  15,   16'h00FF};
    vecs[5] = '{16'd2, 16'hBEEF, 1'b0, 7'd127, 381, 387, 387, 16'hBEEF};

    repeat (3) step();
    check("rst_pitch", 32'(pitch_increment), 32'h0);
    check("rst_gate", 32'(gate), 32'h0);
    check("rst_idx", 32'(step_index), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    rst = 1'b0;
    step();

    foreach (vecs[v]) begin
      wr(0, {vecs[v].inc, vecs[v].rest, vecs[v].dur});
      wr(1, 24'h0);
      tempo_div = vecs[v].tempo;
      loop = 1'b0;
      pulse_start();
      hi = 0; bsy = 0; dn = 0; dn_at = 0; fin = 1'b0; last_p = 16'h0;
      for (n = 1; n <= 600; n++) begin
        if (!busy) begin fin = 1'b1; break; end
        bsy++;
        if (gate) hi++;
        if (done) begin dn++; dn_at = n; end
        last_p = pitch_increment;
        step();
      end
      check($sformatf("vec%0d_finished", v), 32'(fin), 32'h1);
      check($sformatf("vec%0d_gate_hi", v), 32'(hi), 32'(vecs[v].exp_hi));
      check($sformatf("vec%0d_busy", v), 32'(bsy), 32'(vecs[v].exp_busy));
      check($sformatf("vec%0d_done_cnt", v), 32'(dn), 32'h1);
      check($sformatf("vec%0d_done_at", v), 32'(dn_at), 32'(vecs[v].exp_done_at));
      check($sformatf("vec%0d_pitch", v), 32'(last_p), 32'(vecs[v].exp_pitch));
    end

    // stop together with start mid-PLAY
    wr(0, {16'h2222, 1'b0, 7'd10});
    tempo_div = 16'd1;
    pulse_start();
    repeat (4) step();
    check("stop_pre_gate", 32'(gate), 32'h1);
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check("stop_busy", 32'(busy), 32'h0);
    check("stop_gate", 32'(gate), 32'h0);
    check("stop_done", 32'(done), 32'h0);
    dn = 0;
    for (int i = 0; i < 20; i++) begin
      if (done || busy) dn++;
      step();
    end
    check("stop_quiet", 32'(dn), 32'h0);

    // write to the LOADing address in the same cycle: LOAD sees the old empty entry
    wr(0, 24'h0);
    tempo_div = 16'd0;
    pulse_start();
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = {16'h4242, 1'b0, 7'd2};
    step();
    wr_en = 1'b0;
    check("wrload_done", 32'(done), 32'h1);
    check("wrload_gate", 32'(gate), 32'h0);
    step();
    check("wrload_idle", 32'(busy), 32'h0);
    pulse_start();
    step();
    check("wrload_new_gate", 32'(gate), 32'h1);
    check("wrload_new_pitch", 32'(pitch_increment), 32'h4242);
    stop = 1'b1; step(); stop = 1'b0;

    // rewrite entry 0 while it plays in loop mode
    for (int i = 0; i < 16; i++) wr(i, {16'h1000 + 16'(i), 1'b0, 7'd1});
    loop = 1'b1;
    pulse_start();
    step();
    check("rewrite_cur_pitch", 32'(pitch_increment), 32'h1000);
    wr(0, {16'h7777, 1'b0, 7'd1});
    check("rewrite_hold_pitch", 32'(pitch_increment), 32'h1000);
    fin = 1'b0; hi = 0;
    for (int i = 0; i < 200; i++) begin
      if (step_index != 4'd0) hi = 1;
      if (hi == 1 && step_index == 4'd0 && gate) begin fin = 1'b1; break; end
      step();
    end
    check("rewrite_next_pass_seen", 32'(fin), 32'h1);
    check("rewrite_next_pitch", 32'(pitch_increment), 32'h7777);
    stop = 1'b1; step(); stop = 1'b0;

    // async reset mid-play
    loop = 1'b0;
    wr(0, {16'h3333, 1'b0, 7'd50});
    pulse_start();
    repeat (3) step();
    check("arst_pre_gate", 32'(gate), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("arst_gate", 32'(gate), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_pitch", 32'(pitch_increment), 32'h0);
    step();
    rst = 1'b0;
    pulse_start();
    check("arst_load_busy", 32'(busy), 32'h1);
    step();
    check("arst_cleared_done", 32'(done), 32'h1);

    // random tables against the trace model
    rst = 1'b1; step(); rst = 1'b0; step();
    foreach (model_tbl[i]) model_tbl[i] = '0;
    model_pitch = 16'h0;

    // full table of duration-1 notes, looping
    tempo_div = 16'd0;
    loop = 1'b1;
    for (int i = 0; i < 16; i++) begin
      model_tbl[i] = {16'h0100 * 16'(i + 1), 1'b0, 7'd1};
      wr(i, model_tbl[i]);
    end
    build(1, 1'b1, 120);
    run_trace(120, "loop_trace");
    check("loop_wrap", 32'(wrap_seen), 32'h2);
    check("loop_no_done", 32'(done_seen), 32'h0);
    check("loop_gate_rises", 32'(gate_rises), 32'd40);
    model_pitch = exp_q[119].pitch;
    stop = 1'b1; step(); stop = 1'b0;
    check("loop_stop_busy", 32'(busy), 32'h0);

    loop = 1'b0;
    for (int r = 0; r < 8; r++) begin
      int per;
      per = int'($urandom_range(1, 4));
      tempo_div = 16'(per - 1);
      for (int i = 0; i < 16; i++) begin
        logic [6:0] d;
        d = ($urandom_range(0, 9) == 0) ? 7'd0 : 7'($urandom_range(1, 3));
        model_tbl[i] = {16'($urandom), ($urandom_range(0, 3) == 0), d};
        wr(i, model_tbl[i]);
      end
      build(per, 1'b0, 100000);
      run_trace(exp_q.size(), $sformatf("rand%0d", r));
      if (busy) begin stop = 1'b1; step(); stop = 1'b0; end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
